// File: rtl/serv_dbus_pkg.sv
// Shared definitions for the SERV dbus byte-serialising responder.
package serv_dbus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StAck
  } state_e;

  localparam int unsigned NumLanes = 4;
  localparam int unsigned LaneW    = 8;

endpackage

// File: rtl/serv_dbus_byte_resp_if.sv
// Wishbone dbus request/response plus the byte-wide SRAM port of serv_dbus_byte_resp.
interface serv_dbus_byte_resp_if #(
  parameter int unsigned AW = 10
);
  logic [31:0]   adr;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic [31:0]   rdt;
  logic          ack;
  logic [AW-1:0] mem_adr;
  logic          mem_en;
  logic          mem_we;
  logic [7:0]    mem_wdat;
  logic [7:0]    mem_rdat;

  // master: the core side driving requests and also standing in for the SRAM
  modport master (
    output adr, dat, sel, we, cyc, mem_rdat,
    input  rdt, ack, mem_adr, mem_en, mem_we, mem_wdat
  );

  modport slave (
    input  adr, dat, sel, we, cyc, mem_rdat,
    output rdt, ack, mem_adr, mem_en, mem_we, mem_wdat
  );
endinterface

// File: rtl/serv_dbus_byte_resp.sv
// Serialises a 32-bit dbus access into up to four byte accesses on an 8-bit SRAM.
// Optional SERV_DBUS_RESP_RANGE_EN: out-of-range addresses ack immediately with zero data.
module serv_dbus_byte_resp
  import serv_dbus_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serv_dbus_byte_resp_if.slave bus
);

  localparam logic [1:0] LastLane = 2'(NumLanes - 1);

  state_e        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [AW-3:0] adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [31:0]   rdt_q, rdt_d;
  logic          out_of_range;
  logic          cap_en;
  logic [1:0]    cap_lane;

`ifdef SERV_DBUS_RESP_RANGE_EN
  assign out_of_range = |bus.adr[31:AW];
`else
  assign out_of_range = 1'b0;
`endif

  logic unused_adr;
  assign unused_adr = ^{bus.adr[31:AW], bus.adr[1:0]};

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    rdt_d    = rdt_q;
    // Read data for lane k arrives one cycle after its strobe, i.e. while k already points at k+1
    cap_lane = k_q - 2'd1;
    cap_en   = ((state_q == StRun && k_q != 2'd0) || state_q == StDrain) && !we_q &&
               sel_q[cap_lane];
    if (cap_en) begin
      rdt_d[LaneW*cap_lane +: LaneW] = bus.mem_rdat;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.cyc) begin
          rdt_d   = '0;
          k_d     = 2'd0;
          state_d = out_of_range ? StAck : StRun;
        end
      end
      StRun: begin
        k_d = k_q + 2'd1;
        if (k_q == LastLane) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rdt_q   <= rdt_d;
      if (state_q == StIdle && bus.cyc) begin
        adr_q <= bus.adr[AW-1:2];
        dat_q <= bus.dat;
        sel_q <= bus.sel;
        we_q  <= bus.we;
      end
    end
  end

  assign bus.mem_en   = (state_q == StRun) && sel_q[k_q];
  assign bus.mem_we   = bus.mem_en && we_q;
  assign bus.mem_adr  = {adr_q, k_q};
  assign bus.mem_wdat = dat_q[LaneW*k_q +: LaneW];
  assign bus.rdt      = rdt_q;
  assign bus.ack      = (state_q == StAck);

endmodule

// File: tb/tb_serv_dbus_byte_resp.sv
// Self-checking bench for serv_dbus_byte_resp: directed table, random traffic, reset abort.
// Honours SERV_DBUS_RESP_RANGE_EN the same way as the design.
module tb_serv_dbus_byte_resp;

  localparam int unsigned AW       = 10;
  localparam int unsigned MemBytes = 1 << AW;
  localparam int          NumRand  = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serv_dbus_byte_resp_if #(.AW(AW)) bus ();

  serv_dbus_byte_resp #(.AW(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sram    [MemBytes];
  logic [7:0] ref_mem [MemBytes];
  bit         sram_loaded = 1'b0;

  function automatic logic [7:0] fill_byte(input int i);
    return 8'((i * 37 + 5) ^ (i >> 3));
  endfunction

  // Byte-wide synchronous SRAM; read data is garbage except the cycle after a read strobe
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < MemBytes; i++) sram[i] <= fill_byte(i);
      sram_loaded <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      sram[bus.mem_adr] <= bus.mem_wdat;
    end
    if (bus.mem_en && !bus.mem_we) bus.mem_rdat <= sram[bus.mem_adr];
    else                           bus.mem_rdat <= 8'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction, checked cycle by cycle against the transaction-level model
  task automatic run_req(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input bit keep, output logic [31:0] rdt_at_ack);
    logic          in_range;
    int            lat;
    logic [AW-1:0] base;
    logic [AW-1:0] a_k;
    logic [31:0]   exp_rdt;
    logic          exp_en;

    base = {adr[AW-1:2], 2'b00};
`ifdef SERV_DBUS_RESP_RANGE_EN
    in_range = (adr >> AW) == 32'd0;
`else
    in_range = 1'b1;
`endif
    lat     = in_range ? 6 : 1;
    exp_rdt = '0;
    if (in_range && !we) begin
      for (int k = 0; k < 4; k++) begin
        a_k = base | AW'(k);
        if (sel[k]) exp_rdt[8*k +: 8] = ref_mem[a_k];
      end
    end

    bus.adr = adr;
    bus.dat = dat;
    bus.sel = sel;
    bus.we  = we;
    bus.cyc = 1'b1;
    rdt_at_ack = '0;

    @(posedge clk);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      exp_en = 1'b0;
      if (in_range && c <= 4) exp_en = sel[c-1];
      check("mem_en", 32'(bus.mem_en), 32'(exp_en));
      if (exp_en) begin
        a_k = base | AW'(c - 1);
        check("mem_adr", 32'(bus.mem_adr), 32'(a_k));
        check("mem_we", 32'(bus.mem_we), 32'(we));
        if (we) check("mem_wdat", 32'(bus.mem_wdat), 32'(dat[8*(c-1) +: 8]));
      end
      check("ack", 32'(bus.ack), 32'(c == lat));
      if (c == lat) begin
        check("rdt", bus.rdt, exp_rdt);
        rdt_at_ack = bus.rdt;
        if (!keep) bus.cyc = 1'b0;
      end
    end

    if (in_range && we) begin
      for (int k = 0; k < 4; k++) begin
        a_k = base | AW'(k);
        if (sel[k]) ref_mem[a_k] = dat[8*k +: 8];
      end
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    bit          keep;
    logic [31:0] exp_rdt;
  } vec_t;

  localparam int NumVec = 9;
  vec_t vecs [NumVec];

  initial begin
    logic [31:0] got;
    logic [31:0] r_adr;

    vecs[0] = '{32'h0000_0010, 32'hA1B2_C3D4, 4'b1111, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{32'h0000_0010, 32'h0,         4'b0101, 1'b0, 1'b0, 32'h00B2_00D4};
    vecs[2] = '{32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{32'h0000_0010, 32'h0,         4'b1111, 1'b0, 1'b0, 32'hA1B2_C3D4};
    vecs[4] = '{32'h0000_0020, 32'h1122_3344, 4'b1010, 1'b1, 1'b1, 32'h0};
    vecs[5] = '{32'h0000_0023, 32'h0,         4'b1010, 1'b0, 1'b1, 32'h1100_3300};
`ifdef SERV_DBUS_RESP_RANGE_EN
    vecs[6] = '{32'h0000_0413, 32'h0,         4'b1111, 1'b0, 1'b0, 32'h0};
`else
    vecs[6] = '{32'h0000_0413, 32'h0,         4'b1111, 1'b0, 1'b0, 32'hA1B2_C3D4};
`endif
    vecs[7] = '{32'h0000_03FC, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{32'h0000_03FE, 32'h0,         4'b1100, 1'b0, 1'b0, 32'hDEAD_0000};

    for (int i = 0; i < MemBytes; i++) ref_mem[i] = fill_byte(i);
    bus.adr = '0;
    bus.dat = '0;
    bus.sel = '0;
    bus.we  = 1'b0;
    bus.cyc = 1'b0;

    // Reset values, then 20 quiet idle cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdt", bus.rdt, 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
    check("rst_mem_wdat", 32'(bus.mem_wdat), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_ack", 32'(bus.ack), 32'd0);
      check("idle_mem_en", 32'(bus.mem_en), 32'd0);
    end
    check("idle_rdt", bus.rdt, 32'd0);

    for (int i = 0; i < NumVec; i++) begin
      run_req(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, vecs[i].keep, got);
      check($sformatf("vec%0d_rdt", i), got, vecs[i].exp_rdt);
    end

    for (int i = 0; i < NumRand; i++) begin
      r_adr = {22'd0, 4'($urandom_range(0, 15)), 6'd0} | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) r_adr = r_adr | (32'd1 << $urandom_range(AW, 31));
      run_req(r_adr, $urandom, 4'($urandom), 1'($urandom), (i != NumRand - 1) && ($urandom_range(0, 1) == 1), got);
    end

    // Reset during a write, just after the lane 2 strobe
    bus.adr = 32'h0000_0040;
    bus.dat = 32'h5566_7788;
    bus.sel = 4'b1111;
    bus.we  = 1'b1;
    bus.cyc = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("abort_lane2_en", 32'(bus.mem_en), 32'd1);
    check("abort_lane2_adr", 32'(bus.mem_adr), 32'h42);
    rst = 1'b1;
    bus.cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("abort_mem_en", 32'(bus.mem_en), 32'd0);
      check("abort_ack", 32'(bus.ack), 32'd0);
      @(negedge clk);
    end
    check("abort_rdt", bus.rdt, 32'd0);
    ref_mem[AW'(32'h40)] = 8'h88;
    ref_mem[AW'(32'h41)] = 8'h77;
    ref_mem[AW'(32'h42)] = 8'h66;
    run_req(32'h0000_0040, 32'h0, 4'b1111, 1'b0, 1'b0, got);
    check("abort_readback_low", {8'd0, got[23:0]}, 32'h0066_7788);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
